// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI master transmitter between NUM_REQ requesters.
// Sequences start/busy handshake, detects start timeouts and enforces an idle CS gap.
module spi_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 16,
   parameter int GAP_CYCLES  = 4,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        ack,
   output logic [NUM_REQ-1:0]        err,
   output logic                      mst_start,
   output logic [DATA_W-1:0]         mst_data,
   input  logic                      mst_busy,
   output logic                      arb_busy
);

   localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_BUSY,
      BUSY,
      GAP
   } state_t;

   state_t              state, state_n;
   logic [PW-1:0]       ptr, ptr_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic [NUM_REQ-1:0]  gnt_n, ack_n, err_n;
   logic                start_n, arb_busy_n;
   logic [DATA_W-1:0]   data_n;
   logic [PW-1:0]       idx, win;
   logic                found;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= PW'(NUM_REQ - 1);
         cnt       <= '0;
         gnt       <= '0;
         ack       <= '0;
         err       <= '0;
         mst_start <= 1'b0;
         mst_data  <= '0;
         arb_busy  <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         cnt       <= cnt_n;
         gnt       <= gnt_n;
         ack       <= ack_n;
         err       <= err_n;
         mst_start <= start_n;
         mst_data  <= data_n;
         arb_busy  <= arb_busy_n;
      end
   end

   // Rotating search: the requester just served is examined last.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = PW'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      cnt_n   = cnt;
      gnt_n   = gnt;
      ack_n   = '0;
      err_n   = '0;
      start_n = 1'b0;
      data_n  = mst_data;
      unique case (state)
         IDLE: begin
            gnt_n = '0;
            if (found) begin
               gnt_n[win] = 1'b1;
               data_n     = req_data[int'(win)*DATA_W +: DATA_W];
               ptr_n      = win;
               state_n    = START;
            end
         end
         START: begin
            start_n = 1'b1;
            cnt_n   = '0;
            state_n = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (mst_busy) begin
               state_n = BUSY;
            end else if (int'(cnt) == ACK_TIMEOUT - 1) begin
               err_n   = gnt;
               cnt_n   = '0;
               state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         BUSY: begin
            if (!mst_busy) begin
               ack_n   = gnt;
               cnt_n   = '0;
               state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            // gnt stays up through the ack/err cycle, which is the first gap cycle
            gnt_n = '0;
            if (int'(cnt) >= GAP_CYCLES - 1) begin
               state_n = IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      arb_busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Randomized scoreboard bench for spi_tx_arbiter with a round-robin reference model.
// A second instance built with GAP_CYCLES=0 checks back-to-back frame timing.
module tb_spi_tx_arbiter;

   localparam int N   = 4;
   localparam int W   = 16;
   localparam int GAP = 4;
   localparam int TMO = 8;

   typedef struct {
      logic [W-1:0] data;
      bit           tmo;
      int           dly;
      int           len;
   } word_t;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req, gnt, ack, err;
   logic [N*W-1:0] req_data;
   logic           mst_start, mst_busy, arb_busy;
   logic [W-1:0]   mst_data;

   logic [N-1:0]   g_req, g_gnt, g_ack, g_err;
   logic [N*W-1:0] g_data;
   logic           g_start, g_busy, g_arb;
   logic [W-1:0]   g_mdata;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   word_t dq[N][$];
   word_t eq[N][$];
   word_t cur;
   bit    cur_valid = 0;
   int    cur_w = 0;
   logic [N-1:0] drop;

   spi_tx_arbiter #(
      .NUM_REQ(N), .DATA_W(W), .GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data),
      .gnt(gnt), .ack(ack), .err(err), .mst_start(mst_start),
      .mst_data(mst_data), .mst_busy(mst_busy), .arb_busy(arb_busy)
   );

   spi_tx_arbiter #(
      .NUM_REQ(N), .DATA_W(W), .GAP_CYCLES(0), .ACK_TIMEOUT(TMO)
   ) dut_g0 (
      .clk(clk), .reset(reset), .req(g_req), .req_data(g_data),
      .gnt(g_gnt), .ack(g_ack), .err(g_err), .mst_start(g_start),
      .mst_data(g_mdata), .mst_busy(g_busy), .arb_busy(g_arb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic issue(input int i, input logic [W-1:0] d, input bit t,
                        input int dl, input int ln);
      word_t w;
      w.data = d;
      w.tmo  = t;
      w.dly  = dl;
      w.len  = ln;
      dq[i].push_back(w);
      eq[i].push_back(w);
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < N; i++) s += dq[i].size() + eq[i].size();
      return s;
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (n < 3000 && !(dq_empty() && !arb_busy && req == '0)) begin
         @(posedge clk);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: arbiter still busy after %0d cycles", n);
      end
      repeat (2) @(posedge clk);
   endtask

   function automatic bit dq_empty();
      for (int i = 0; i < N; i++) if (dq[i].size() != 0) return 0;
      return 1;
   endfunction

   // Requesters: hold req until ack/err, drop for one cycle, then serve the next word.
   initial begin
      req = '0;
      req_data = '0;
      drop = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (reset) begin
               req[i] = 1'b0;
               drop[i] = 1'b0;
            end else if (ack[i] || err[i]) begin
               if (dq[i].size() != 0) dq[i].delete(0);
               drop[i] = 1'b1;
            end else if (drop[i]) begin
               drop[i] = 1'b0;
               req[i] = 1'b0;
            end else if (gnt[i]) begin
               req_data[i*W +: W] = W'($urandom);
            end else if (dq[i].size() != 0) begin
               req[i] = 1'b1;
               req_data[i*W +: W] = dq[i][0].data;
            end
         end
      end
   end

   // SPI master model: busy after dly cycles for len cycles, or never for timeout words.
   initial begin
      int mph, mcnt, mlen;
      mst_busy = 1'b0;
      mph = 0;
      mcnt = 0;
      mlen = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            mst_busy = 1'b0;
            mph = 0;
         end else if (mph == 0) begin
            if (mst_start && cur_valid && !cur.tmo) begin
               mcnt = cur.dly;
               mlen = cur.len;
               mph = 1;
            end
         end else if (mph == 1) begin
            mcnt--;
            if (mcnt == 0) begin
               mst_busy = 1'b1;
               mcnt = mlen;
               mph = 2;
            end
         end else begin
            mcnt--;
            if (mcnt == 0) begin
               mst_busy = 1'b0;
               mph = 0;
            end
         end
      end
   end

   // Monitor: expected winner is the first requester after the last served one
   // among those requesting when the arbiter sampled.
   initial begin
      int last, exp_w, g_cyc, s_cyc, f_cyc, e_cyc;
      bit gap_pend, prev_busy, prev_arb;
      logic [N-1:0] prev_gnt, prev_req;
      last = N - 1;
      g_cyc = 0; s_cyc = 0; f_cyc = -100; e_cyc = 0;
      gap_pend = 0; prev_busy = 0; prev_arb = 0;
      prev_gnt = '0; prev_req = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            cur_valid = 0;
            last = N - 1;
            prev_gnt = '0; prev_req = '0;
            prev_busy = 0; prev_arb = 0;
            gap_pend = 0;
            f_cyc = -100;
         end else begin
            chk("onehot", {$countones(gnt) <= 1, $countones(ack) <= 1,
                           $countones(err) <= 1, !(|ack && |err)}, 4'hF);
            if (!prev_arb && |prev_req) chk("grant_lat", |gnt, 1);
            if (gnt != '0 && gnt != prev_gnt) begin
               exp_w = -1;
               for (int k = 1; k <= N; k++) begin
                  int j;
                  j = (last + k) % N;
                  if (exp_w < 0 && prev_req[j]) exp_w = j;
               end
               if (exp_w < 0) begin
                  chk("grant_unexpected", gnt, 0);
               end else begin
                  chk("grant", gnt, 1 << exp_w);
                  if (eq[exp_w].size() == 0) begin
                     chk("grant_nodata", eq[exp_w].size(), 1);
                  end else begin
                     cur = eq[exp_w].pop_front();
                     cur_valid = 1;
                     cur_w = exp_w;
                     chk("data", mst_data, cur.data);
                  end
                  last = exp_w;
               end
               g_cyc = cyc;
            end
            if (mst_start) begin
               chk("start_lat", cyc - g_cyc, 1);
               chk("start_sep", (cyc - f_cyc) >= 5, 1);
               s_cyc = cyc;
            end
            if (prev_busy && !mst_busy) f_cyc = cyc;
            if (|ack) begin
               chk("ack_valid", cur_valid, 1);
               chk("ack", ack, 1 << cur_w);
               chk("ack_kind", cur.tmo, 0);
               chk("ack_lat", cyc - f_cyc, 1);
               chk("ack_gnt", gnt, ack);
               chk("data_hold", mst_data, cur.data);
               cur_valid = 0;
               e_cyc = cyc;
               gap_pend = 1;
            end
            if (|err) begin
               chk("err_valid", cur_valid, 1);
               chk("err", err, 1 << cur_w);
               chk("err_kind", cur.tmo, 1);
               chk("err_lat", cyc - s_cyc, TMO);
               cur_valid = 0;
               e_cyc = cyc;
               gap_pend = 1;
            end
            if (gap_pend && cyc == e_cyc + GAP - 1) chk("gap_busy", arb_busy, 1);
            if (gap_pend && cyc == e_cyc + GAP) begin
               chk("gap_idle", arb_busy, 0);
               gap_pend = 0;
            end
            if (cur_valid && cyc - g_cyc > 300) begin
               chk("frame_end", 0, 1);
               cur_valid = 0;
            end
            prev_gnt = gnt;
            prev_req = req;
            prev_busy = mst_busy;
            prev_arb = arb_busy;
         end
      end
   end

   task automatic gap0_test();
      int a1, s1, s2, n, mt;
      logic [N-1:0] g2, gdrop;
      a1 = -1; s1 = -1; s2 = -1; n = 0; mt = 0;
      g2 = '0; gdrop = '0;
      g_data = {16'h0, 16'h0, 16'hBEEF, 16'hCAFE};
      g_req = 4'b0011;
      while (n < 200 && s2 < 0) begin
         @(posedge clk);
         #1;
         n++;
         if (g_start) begin
            mt = 4;
         end else if (mt > 0) begin
            mt--;
            g_busy = (mt != 0);
         end
         for (int i = 0; i < 2; i++) begin
            if (gdrop[i]) begin
               g_req[i] = 1'b0;
               gdrop[i] = 1'b0;
            end
            if (g_ack[i]) gdrop[i] = 1'b1;
         end
         if (|g_ack && a1 < 0) a1 = cyc;
         if (g_start) begin
            if (s1 < 0) s1 = cyc;
            else if (a1 >= 0) begin
               s2 = cyc;
               g2 = g_gnt;
            end
         end
      end
      chk("g0_start_gap", s2 - a1, 2);
      chk("g0_second", g2, 4'b0010);
      g_req = '0;
      g_busy = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      g_req = '0;
      g_data = '0;
      g_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", {gnt, ack, err, mst_start, arb_busy, mst_data}, 0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      repeat (2) @(posedge clk);

      issue(0, 16'h1111, 0, 2, 10);
      issue(1, 16'h2222, 0, 3, 6);
      issue(2, 16'h3333, 0, 1, 4);
      issue(3, 16'h4444, 0, 2, 8);
      issue(0, 16'h5555, 0, 2, 5);
      wait_idle();

      issue(0, 16'hA55A, 0, 2, 20);
      wait_idle();

      issue(1, 16'h0B0B, 0, 2, 5);
      wait_idle();
      issue(0, 16'h0A0A, 0, 3, 4);
      issue(1, 16'h1B1B, 0, 1, 4);
      wait_idle();

      issue(2, 16'hDEAD, 1, 1, 1);
      wait_idle();
      issue(2, 16'hBEEF, 0, 2, 6);
      wait_idle();

      for (int r = 0; r < 60; r++) begin
         int i;
         repeat ($urandom_range(0, 12)) @(posedge clk);
         i = $urandom_range(0, N - 1);
         if (dq[i].size() < 3)
            issue(i, W'($urandom), ($urandom_range(0, 5) == 0),
                  $urandom_range(1, 6), $urandom_range(1, 25));
      end
      wait_idle();

      issue(2, 16'h7E7E, 0, 2, 30);
      n = 0;
      while (!mst_busy && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("busy_seen", mst_busy, 1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("rst_async", {gnt, ack, err, mst_start, arb_busy, mst_data}, 0);
      for (int i = 0; i < N; i++) begin
         dq[i].delete();
         eq[i].delete();
      end
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;
      issue(3, 16'h3C3C, 0, 2, 4);
      issue(1, 16'h1C1C, 0, 2, 4);
      wait_idle();
      issue(3, 16'h8000, 0, 1, 3);
      wait_idle();

      gap0_test();

      chk("drain", pending(), 0);
      chk("open_frame", cur_valid, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
